// File: rtl/uart_tx_feeder.sv
// Byte FIFO that sits in front of the UART transmitter. It hands one byte at a
// time to the transmitter and waits for that frame to finish before sending the next.
module uart_tx_feeder #(
   parameter int DATA_WIDTH  = 8,
   parameter int DEPTH       = 8,
   parameter int ADDR_W      = 3,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WR_EN,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   output logic                  FULL,
   output logic                  EMPTY,
   output logic [ADDR_W:0]       COUNT,
   output logic                  OVF,
   input  logic                  TX_BUSY,
   output logic                  TX_DATA_VALID,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  ACK_ERR
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_ISSUE     = 2'd1;
   localparam logic [1:0] S_WAIT_BUSY = 2'd2;
   localparam logic [1:0] S_WAIT_DONE = 2'd3;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0]     r_wrPtr;
   logic [ADDR_W-1:0]     r_rdPtr;
   logic [CNT_W-1:0]      r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_ovf;
   logic [1:0]            r_state;
   logic [TMR_W-1:0]      r_timer;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_pData;
   logic                  r_ackErr;

   logic                  w_wrAccept;
   logic                  w_pop;
   logic [CNT_W-1:0]      w_countNext;

   // FULL is the registered flag, so a pop on the same edge never frees room for a write.
   assign w_wrAccept = WR_EN && !r_full;
   assign w_pop      = (r_state == S_IDLE) && !r_empty && !TX_BUSY;

   always_comb begin
      w_countNext = r_count;
      if (w_wrAccept && !w_pop) begin
         w_countNext = r_count + CNT_W'(1);
      end else if (!w_wrAccept && w_pop) begin
         w_countNext = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (w_wrAccept) begin
         r_mem[r_wrPtr] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wrAccept) begin
            r_wrPtr <= r_wrPtr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + ADDR_W'(1);
         end
         r_count <= w_countNext;
         r_full  <= (w_countNext == CNT_W'(DEPTH));
         r_empty <= (w_countNext == '0);
         r_ovf   <= WR_EN && r_full;
      end
   end

   // Issue sequencer: the byte is lost if the transmitter never acknowledges it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_timer  <= '0;
         r_valid  <= 1'b0;
         r_pData  <= '0;
         r_ackErr <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_state <= S_ISSUE;
                  r_valid <= 1'b1;
                  r_pData <= r_mem[r_rdPtr];
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT_BUSY;
               r_timer <= '0;
            end
            S_WAIT_BUSY: begin
               if (TX_BUSY) begin
                  r_state <= S_WAIT_DONE;
               end else if (r_timer == TMR_W'(ACK_TIMEOUT - 1)) begin
                  r_ackErr <= 1'b1;
                  r_state  <= S_IDLE;
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            S_WAIT_DONE: begin
               if (!TX_BUSY) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign FULL          = r_full;
   assign EMPTY         = r_empty;
   assign COUNT         = r_count;
   assign OVF           = r_ovf;
   assign TX_DATA_VALID = r_valid;
   assign TX_P_DATA     = r_pData;
   assign ACK_ERR       = r_ackErr;

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte-buffering front end that sits directly upstream of the UART transmitter FSM/serializer.
- Accepts bytes from the system side into a small synchronous FIFO.
- Issues each byte to the transmitter as a one-cycle Data_Valid pulse with stable parallel data, only when the transmitter reports not busy.
- Tracks the transmitter's registered busy flag so exactly one byte is in flight at a time.

Parameters:
- DATA_WIDTH, 8: byte width on WR_DATA and TX_P_DATA.
- DEPTH, 8: FIFO entries; must be a power of two, at least 2.
- ADDR_W, 3: log2(DEPTH); pointer width.
- ACK_TIMEOUT, 4: cycles allowed in WAIT_BUSY for TX_BUSY to rise after an issue.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- WR_EN  input  1  write request; a byte is accepted on a clock edge where WR_EN=1 and FULL=0.
- WR_DATA  input  DATA_WIDTH  byte to enqueue.
- FULL  output  1  COUNT==DEPTH.
- EMPTY  output  1  COUNT==0.
- COUNT  output  ADDR_W+1  occupancy, 0..DEPTH.
- OVF  output  1  one-cycle pulse: write attempted while FULL; the byte is dropped.
- TX_BUSY  input  1  registered busy from the UART transmitter FSM.
- TX_DATA_VALID  output  1  one-cycle issue strobe to the transmitter.
- TX_P_DATA  output  DATA_WIDTH  byte being issued; held until the next issue.
- ACK_ERR  output  1  sticky flag: TX_BUSY never rose within ACK_TIMEOUT; cleared only by RST.

Behaviour:
- Reset (async, RST=1): all pointers and COUNT = 0; EMPTY=1, FULL=0, OVF=0, TX_DATA_VALID=0, TX_P_DATA=0, ACK_ERR=0; state = IDLE.
- Reset mid-transfer discards FIFO contents and any in-flight tracking. The transmitter is not notified.
- All outputs are registered.
- FIFO write:
  - Accepted if WR_EN && !FULL; data goes to mem[wr_ptr] and wr_ptr wraps modulo DEPTH.
  - WR_EN && FULL: byte dropped and OVF=1 for the following cycle.
  - FULL is evaluated on the pre-edge COUNT. A same-cycle pop does not make room for a same-cycle write.
- FIFO read (pop) happens only on the IDLE->ISSUE transition; rd_ptr wraps modulo DEPTH.
- COUNT update:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous accepted write and pop.
- State machine: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !EMPTY && !TX_BUSY, go to ISSUE. At that edge, TX_P_DATA <= mem[rd_ptr], TX_DATA_VALID <= 1, and the entry is popped. Otherwise stay.
  - ISSUE: lasts exactly one cycle (TX_DATA_VALID=1). Next state WAIT_BUSY; TX_DATA_VALID <= 0.
  - WAIT_BUSY: if TX_BUSY=1, go to WAIT_DONE. If ACK_TIMEOUT cycles elapse in this state without it, set ACK_ERR=1 and go to IDLE (the byte is lost).
  - WAIT_DONE: stay while TX_BUSY=1; on TX_BUSY=0, go to IDLE.
- Issue latency:
  - A byte written into an empty FIFO at edge k sees EMPTY=0 after k.
  - With TX idle, TX_DATA_VALID=1 in the cycle after edge k+1.
- Throughput: one byte per transmitter frame plus 2 idle cycles. Back-to-back STOP->START chaining in the transmitter is not used.
- TX_DATA_VALID never asserts while TX_BUSY=1 or EMPTY=1.
- TX_DATA_VALID never asserts for two consecutive cycles.
- The transmitter raises TX_BUSY 2 cycles after TX_DATA_VALID, which is within ACK_TIMEOUT=4.
- Writes are accepted in every state; the FIFO is independent of the issue FSM.

Test Plan:
- RST pulse mid-run with 3 bytes queued and one in flight -> all outputs at reset values immediately. After release, no TX_DATA_VALID until a new write.
- Single write 0xA5, TX_BUSY model rises 2 cycles after strobe and stays high 11 cycles -> one TX_DATA_VALID pulse with TX_P_DATA=0xA5, issued 2 edges after the write; COUNT 1->0; FSM returns to IDLE after busy falls.
- Write 8 bytes 0x01..0x08 back-to-back with TX_BUSY held high -> FULL=1, COUNT=8. A 9th write 0xFF gives OVF pulse and is dropped. Releasing TX_BUSY yields 0x01..0x08 in order, one per busy cycle, with pointer wrap exercised.
- FIFO at COUNT=8 with simultaneous write and pop -> write rejected (OVF=1), COUNT=7.
- TX_BUSY tied low after issue of 0x3C -> after 4 cycles in WAIT_BUSY, ACK_ERR=1 sticky. Next queued byte 0x3D is still issued.
- Enqueue 0x11 while TX_BUSY=1 from an unrelated frame -> no TX_DATA_VALID until TX_BUSY=0, then issue on the next edge.
